// File: rtl/prim_sparse_fsm_decoder_pkg.sv
// Shared types and constants for the sparse FSM state decoder.
// Alert FSM encodings keep pairwise Hamming distance >= 3 so single/double flips never alias.
package prim_sparse_fsm_decoder_pkg;

  localparam int unsigned AlertStateW = 5;

  typedef enum logic [AlertStateW-1:0] {
    AlertIdle     = 5'b01010,
    AlertReq      = 5'b10110,
    AlertWaitDrop = 5'b11001,
    AlertFatal    = 5'b00101
  } alert_state_e;

  localparam int unsigned DefaultWidth     = 10;
  localparam int unsigned DefaultNumStates = 4;

  // Packed array: the rightmost literal is entry 0, so 10'h0A5 decodes to index 0.
  localparam logic [DefaultNumStates-1:0][DefaultWidth-1:0] DefaultStateEncodings = {
    10'h2B3, 10'h36C, 10'h1DA, 10'h0A5
  };

  function automatic int unsigned popcount64(input logic [63:0] value);
    int unsigned cnt;
    cnt = 0;
    for (int b = 0; b < 64; b++) begin
      cnt = cnt + 32'(value[b]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prim_sparse_fsm_decoder_alert.sv
// Four-phase alert sender FSM with a one-deep pending queue and a terminal Fatal state.
// Any state register value outside the sparse set collapses into Fatal.
module prim_sparse_fsm_decoder_alert
  import prim_sparse_fsm_decoder_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic err_i,
  input  logic alert_ack_i,
  output logic alert_req_o
);

  logic [AlertStateW-1:0] state_r;
  logic [AlertStateW-1:0] state_n_s;
  logic                   pend_r;
  logic                   pend_n_s;
  logic                   req_r;
  logic                   req_n_s;

  // State, pend and registered request flops
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= AlertIdle;
      pend_r  <= 1'b0;
      req_r   <= 1'b0;
    end else begin
      state_r <= state_n_s;
      pend_r  <= pend_n_s;
      req_r   <= req_n_s;
    end
  end

  // Next-state and pend update
  always_comb begin
    state_n_s = state_r;
    pend_n_s  = pend_r;
    case (state_r)
      AlertIdle: begin
        if (err_i || pend_r) begin
          state_n_s = AlertReq;
          pend_n_s  = 1'b0;
        end else begin
          state_n_s = AlertIdle;
        end
      end
      AlertReq: begin
        if (err_i) begin
          pend_n_s = 1'b1;
        end else begin
          pend_n_s = pend_r;
        end
        if (alert_ack_i) begin
          state_n_s = AlertWaitDrop;
        end else begin
          state_n_s = AlertReq;
        end
      end
      AlertWaitDrop: begin
        if (err_i) begin
          pend_n_s = 1'b1;
        end else begin
          pend_n_s = pend_r;
        end
        if (!alert_ack_i) begin
          state_n_s = AlertIdle;
        end else begin
          state_n_s = AlertWaitDrop;
        end
      end
      AlertFatal: begin
        state_n_s = AlertFatal;
      end
      default: begin
        state_n_s = AlertFatal;
      end
    endcase
  end

  // Request decode from the next state, so the flop mirrors the state it accompanies
  always_comb begin
    req_n_s = 1'b0;
    if ((state_n_s == AlertReq) || (state_n_s == AlertFatal)) begin
      req_n_s = 1'b1;
    end else begin
      req_n_s = 1'b0;
    end
  end

  assign alert_req_o = req_r;

endmodule

// File: rtl/prim_sparse_fsm_decoder_chk.sv
// Elaboration-time check that the legal encodings are distinct and at least distance 2 apart.
module prim_sparse_fsm_decoder_chk
  import prim_sparse_fsm_decoder_pkg::*;
#(
  parameter int unsigned Width     = DefaultWidth,
  parameter int unsigned NumStates = DefaultNumStates,
  parameter logic [NumStates-1:0][Width-1:0] StateEncodings = DefaultStateEncodings
) ();

  function automatic bit encodings_ok();
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < int'(NumStates); i++) begin
      for (int j = i + 1; j < int'(NumStates); j++) begin
        ok = ok & (popcount64(64'(StateEncodings[i] ^ StateEncodings[j])) >= 32'd2);
      end
    end
    return ok;
  endfunction

  localparam bit EncOk = encodings_ok();

  if (!EncOk) begin : g_enc_bad
    $fatal(1, "StateEncodings must be distinct with pairwise Hamming distance >= 2");
  end

endmodule

// File: rtl/prim_sparse_fsm_decoder.sv
// Decodes a sparse FSM state word to index/one-hot, and flags, counts and escalates
// any word outside the legal encoding set.
module prim_sparse_fsm_decoder
  import prim_sparse_fsm_decoder_pkg::*;
#(
  parameter int unsigned Width     = DefaultWidth,
  parameter int unsigned NumStates = DefaultNumStates,
  parameter logic [NumStates-1:0][Width-1:0] StateEncodings = DefaultStateEncodings,
  parameter int unsigned ErrCntW   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [Width-1:0]             state_i,
  input  logic                         clr_i,
  input  logic                         alert_ack_i,
  output logic [$clog2(NumStates)-1:0] state_idx_o,
  output logic [NumStates-1:0]         state_onehot_o,
  output logic                         err_o,
  output logic                         err_sticky_o,
  output logic [ErrCntW-1:0]           err_cnt_o,
  output logic                         alert_req_o
);

  localparam int unsigned IdxW = $clog2(NumStates);
  localparam logic [ErrCntW-1:0] CntMax = {ErrCntW{1'b1}};

  logic [NumStates-1:0] match_s;
  logic [IdxW-1:0]      idx_s;
  logic                 legal_s;
  logic                 sticky_n_s;
  logic [ErrCntW-1:0]   cnt_n_s;

  logic [IdxW-1:0]      state_idx_r;
  logic [NumStates-1:0] onehot_r;
  logic                 err_r;
  logic                 sticky_r;
  logic [ErrCntW-1:0]   cnt_r;

  // Comparator array against every legal encoding
  always_comb begin
    match_s = '0;
    for (int i = 0; i < int'(NumStates); i++) begin
      match_s[i] = (state_i == StateEncodings[i]);
    end
  end

  // Binary encode; encodings are distinct so at most one match bit is set
  always_comb begin
    idx_s = '0;
    for (int i = 0; i < int'(NumStates); i++) begin
      idx_s = idx_s | (match_s[i] ? IdxW'(i) : {IdxW{1'b0}});
    end
  end

  assign legal_s = |match_s;

  // Sticky and saturating counter update; an illegal sample beats a same-cycle clear
  always_comb begin
    sticky_n_s = sticky_r;
    cnt_n_s    = cnt_r;
    if (!legal_s) begin
      sticky_n_s = 1'b1;
      if (clr_i) begin
        cnt_n_s = ErrCntW'(1);
      end else if (cnt_r == CntMax) begin
        cnt_n_s = cnt_r;
      end else begin
        cnt_n_s = cnt_r + ErrCntW'(1);
      end
    end else if (clr_i) begin
      sticky_n_s = 1'b0;
      cnt_n_s    = '0;
    end else begin
      sticky_n_s = sticky_r;
      cnt_n_s    = cnt_r;
    end
  end

  // Decode and error bookkeeping registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_idx_r <= '0;
      onehot_r    <= '0;
      err_r       <= 1'b0;
      sticky_r    <= 1'b0;
      cnt_r       <= '0;
    end else begin
      if (legal_s) begin
        state_idx_r <= idx_s;
      end else begin
        state_idx_r <= state_idx_r;
      end
      onehot_r <= legal_s ? match_s : {NumStates{1'b0}};
      err_r    <= ~legal_s;
      sticky_r <= sticky_n_s;
      cnt_r    <= cnt_n_s;
    end
  end

  prim_sparse_fsm_decoder_alert u_alert (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .err_i       (~legal_s),
    .alert_ack_i (alert_ack_i),
    .alert_req_o (alert_req_o)
  );

  prim_sparse_fsm_decoder_chk #(
    .Width          (Width),
    .NumStates      (NumStates),
    .StateEncodings (StateEncodings)
  ) u_chk ();

  assign state_idx_o    = state_idx_r;
  assign state_onehot_o = onehot_r;
  assign err_o          = err_r;
  assign err_sticky_o   = sticky_r;
  assign err_cnt_o      = cnt_r;

endmodule

// File: tb/tb_prim_sparse_fsm_decoder.sv
// Directed plus randomized bench for prim_sparse_fsm_decoder against a behavioural model.
module tb_prim_sparse_fsm_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] state;
  logic       clr;
  logic       ack;
  logic [1:0] state_idx;
  logic [3:0] onehot;
  logic       err;
  logic       sticky;
  logic [3:0] cnt;
  logic       req;

  int total = 0;
  int bad   = 0;

  int enc[4];

  // Model: decode results plus a handshake view (busy = handshake open, req = still requesting)
  int m_idx, m_oh, m_err, m_sticky, m_cnt;
  bit m_busy, m_req, m_queued, m_fatal;

  prim_sparse_fsm_decoder dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .state_i        (state),
    .clr_i          (clr),
    .alert_ack_i    (ack),
    .state_idx_o    (state_idx),
    .state_onehot_o (onehot),
    .err_o          (err),
    .err_sticky_o   (sticky),
    .err_cnt_o      (cnt),
    .alert_req_o    (req)
  );

  always #5 clk = ~clk;

  function automatic int lookup(input logic [9:0] w);
    for (int k = 0; k < 4; k++) begin
      if (enc[k] == int'(w)) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_idx = 0; m_oh = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
    m_busy = 1'b0; m_req = 1'b0; m_queued = 1'b0; m_fatal = 1'b0;
  endtask

  task automatic model_step(input logic [9:0] w, input bit c, input bit a);
    int k;
    k = lookup(w);
    if (k >= 0) begin
      m_idx = k; m_oh = 1 << k; m_err = 0;
    end else begin
      m_oh = 0; m_err = 1;
    end
    if (k < 0) m_sticky = 1;
    else if (c) m_sticky = 0;
    if (k < 0) m_cnt = c ? 1 : ((m_cnt < 15) ? m_cnt + 1 : 15);
    else if (c) m_cnt = 0;
    if (m_fatal) begin
      m_req = 1'b1;
    end else if (!m_busy) begin
      if (k < 0 || m_queued) begin
        m_busy = 1'b1; m_req = 1'b1; m_queued = 1'b0;
      end
    end else begin
      if (k < 0) m_queued = 1'b1;
      if (m_req) begin
        if (a) m_req = 1'b0;
      end else if (!a) begin
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state_idx", 32'(state_idx), m_idx);
    check("onehot", 32'(onehot), m_oh);
    check("err", 32'(err), m_err);
    check("sticky", 32'(sticky), m_sticky);
    check("cnt", 32'(cnt), m_cnt);
    check("alert_req", 32'(req), 32'(m_req));
  endtask

  task automatic cycle(input logic [9:0] w, input bit c, input bit a);
    state = w; clr = c; ack = a;
    @(posedge clk);
    model_step(w, c, a);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] r;
    enc[0] = 10'h0A5; enc[1] = 10'h1DA; enc[2] = 10'h36C; enc[3] = 10'h2B3;
    rst = 1'b0; clr = 1'b0; ack = 1'b0; state = 10'h0A5;
    model_reset();
    #2 rst = 1'b1;
    #1 check_all();
    @(negedge clk) rst = 1'b0;

    // Legal decode, then one illegal word and a full handshake
    cycle(10'h36C, 1'b0, 1'b0);
    cycle(10'h000, 1'b0, 1'b0);
    cycle(10'h36C, 1'b0, 1'b1);
    cycle(10'h36C, 1'b0, 1'b1);
    cycle(10'h36C, 1'b0, 1'b0);

    // Second illegal sample while requesting queues exactly one extra alert
    cycle(10'h000, 1'b0, 1'b0);
    cycle(10'h3FF, 1'b0, 1'b0);
    cycle(10'h0A5, 1'b0, 1'b1);
    cycle(10'h0A5, 1'b0, 1'b0);
    cycle(10'h0A5, 1'b0, 1'b0);
    cycle(10'h0A5, 1'b0, 1'b1);
    cycle(10'h0A5, 1'b0, 1'b0);
    cycle(10'h0A5, 1'b0, 1'b0);

    // Counter saturation and clear interaction
    for (int i = 0; i < 20; i++) cycle(10'h155, 1'b0, 1'b0);
    cycle(10'h155, 1'b1, 1'b0);
    cycle(10'h2B3, 1'b1, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      if (r[0]) state = 10'(enc[$urandom_range(0, 3)]);
      else      state = r[10:1];
      cycle(state, ($urandom_range(0, 7) == 0), r[20]);
    end

    // Mid-handshake asynchronous reset
    cycle(10'h000, 1'b0, 1'b0);
    cycle(10'h001, 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    cycle(10'h1DA, 1'b0, 1'b0);
    cycle(10'h2B3, 1'b0, 1'b1);

    // Corrupted alert state register -> Fatal, sticky until reset
    @(negedge clk);
    force dut.u_alert.state_r = 5'b11111;
    m_fatal = 1'b1;
    cycle(10'h0A5, 1'b0, 1'b1);
    release dut.u_alert.state_r;
    for (int i = 0; i < 8; i++) cycle(10'(enc[i % 4]), 1'b0, i[0]);
    cycle(10'h000, 1'b1, 1'b1);
    @(negedge clk) rst = 1'b1;
    model_reset();
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    cycle(10'h36C, 1'b0, 1'b0);
    cycle(10'h36C, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
